// File: rtl/dffram_wb_ctrl.sv
// dffram_wb_ctrl: Wishbone B4 classic slave in front of a 2048x32 DFFRAM macro.
// Every bus request runs IDLE -> ACCESS -> RESP, so the macro sees exactly one
// EN cycle per transfer and its registered Do is valid while the ack is up.
// Optional build macro: DFFRAM_WB_ERR_EN enables address decode against
// BASE_ADDR; out-of-window requests answer with wb_err_o and never touch the RAM.
module dffram_wb_ctrl #(
    parameter int          A_WIDTH   = 11,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    input  logic               wb_we_i,
    input  logic [3:0]         wb_sel_i,
    input  logic [31:0]        wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    output logic [31:0]        wb_dat_o,
    output logic               wb_ack_o,
    output logic               wb_err_o,
    output logic               ram_EN,
    output logic [3:0]         ram_WE,
    output logic [A_WIDTH-1:0] ram_A,
    output logic [31:0]        ram_Di,
    input  logic [31:0]        ram_Do
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [A_WIDTH-1:0] adr_reg, adr_next;
    logic [31:0]        dat_reg, dat_next;
    logic [3:0]         sel_reg, sel_next;
    logic               we_reg, we_next;
    logic               err_reg, err_next;

    logic req;
    logic addr_miss;
    logic in_access;
    logic in_resp;
    logic unused_bits;

    assign req = wb_cyc_i & wb_stb_i;

`ifdef DFFRAM_WB_ERR_EN
    // Requests outside the aligned window around BASE_ADDR are rejected.
    assign addr_miss   = (wb_adr_i[31:A_WIDTH+2] != BASE_ADDR[31:A_WIDTH+2]);
    assign unused_bits = ^{wb_adr_i[1:0], BASE_ADDR[A_WIDTH+1:0]};
`else
    // Upper address bits ignored: the RAM aliases across the address space.
    assign addr_miss   = 1'b0;
    assign unused_bits = ^{wb_adr_i[31:A_WIDTH+2], wb_adr_i[1:0], BASE_ADDR};
`endif

    // State and request-latch registers; reset returns to IDLE with everything cleared.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
            adr_reg   <= '0;
            dat_reg   <= '0;
            sel_reg   <= '0;
            we_reg    <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            adr_reg   <= adr_next;
            dat_reg   <= dat_next;
            sel_reg   <= sel_next;
            we_reg    <= we_next;
            err_reg   <= err_next;
        end
    end

    // Next-state logic: latch the request in IDLE, then a fixed walk to RESP and back.
    always_comb begin
        state_next = state_reg;
        adr_next   = adr_reg;
        dat_next   = dat_reg;
        sel_next   = sel_reg;
        we_next    = we_reg;
        err_next   = err_reg;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    adr_next   = wb_adr_i[A_WIDTH+1:2];
                    dat_next   = wb_dat_i;
                    sel_next   = wb_sel_i;
                    we_next    = wb_we_i;
                    err_next   = addr_miss;
                    state_next = addr_miss ? RESP : ACCESS;
                end
            end
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign in_access = (state_reg == ACCESS);
    assign in_resp   = (state_reg == RESP);

    // RAM strobes come only from registered state; RST gates them so a reset
    // landing in ACCESS can never commit a partial write.
    assign ram_EN = in_access & ~RST;
    assign ram_A  = adr_reg;
    assign ram_Di = dat_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_we_lane
            assign ram_WE[gi] = in_access & we_reg & sel_reg[gi] & ~RST;
        end
    endgenerate

    // Bus response: ack follows cyc in RESP so a dropped cycle suppresses it.
    assign wb_ack_o = in_resp & ~err_reg & wb_cyc_i & ~RST;
    assign wb_dat_o = (in_resp & ~we_reg & ~err_reg) ? ram_Do : 32'h0;

`ifdef DFFRAM_WB_ERR_EN
    assign wb_err_o = in_resp & err_reg & wb_cyc_i & ~RST;
`else
    assign wb_err_o = 1'b0;
`endif

endmodule
